// File: rtl/rand_range_sampler.sv
// Bounded uniform sampler: masks the LFSR state to the bound's bit length and rejects
// out-of-range draws, with a deterministic fallback after MAX_TRIES draw cycles.
module rand_range_sampler #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8,
  parameter int MAX_TRIES = 16,
  parameter int STAT_W    = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [31:0]       lfsr_state_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [DATA_W-1:0] req_bound_i,
  input  logic [CNT_W-1:0]  req_count_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic [STAT_W-1:0] stat_rejects_o,
  output logic [STAT_W-1:0] stat_fallbacks_o
);

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAW, ST_HOLD} state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   bound_reg, bound_next;
  logic [DATA_W-1:0]   mask_reg, mask_next;
  logic [CNT_W-1:0]    remaining_reg, remaining_next;
  logic [TRY_W-1:0]    tries_reg, tries_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                last_reg, last_next;
  logic                valid_reg, valid_next;
  logic [STAT_W-1:0]   rejects_reg, rejects_next;
  logic [STAT_W-1:0]   fallbacks_reg, fallbacks_next;

  logic [DATA_W-1:0]   bound_m1;
  logic [DATA_W-1:0]   req_mask;
  logic [DATA_W-1:0]   draw_s;
  logic                draw_hit;
  logic [DATA_W-1:0]   fallback_val;
  logic                is_last;

  // Smearing (bound-1) downward gives all-ones over its bit length; bound 0 wraps to all-ones.
  assign bound_m1 = req_bound_i - DATA_W'(1);

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
      assign req_mask[gi] = |bound_m1[DATA_W-1:gi];
    end
    if (DATA_W < 32) begin : g_lfsr_hi
      logic unused_lfsr_hi;
      assign unused_lfsr_hi = ^lfsr_state_i[31:DATA_W];
    end
  endgenerate

  assign draw_s       = lfsr_state_i[DATA_W-1:0] & mask_reg;
  assign draw_hit     = (bound_reg == '0) || (draw_s < bound_reg);
  // Masked draw is below 2*bound, so subtracting once always lands in range.
  assign fallback_val = draw_s - bound_reg;
  assign is_last      = (remaining_reg == CNT_W'(1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg     <= ST_IDLE;
      bound_reg     <= '0;
      mask_reg      <= '0;
      remaining_reg <= '0;
      tries_reg     <= '0;
      data_reg      <= '0;
      last_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      rejects_reg   <= '0;
      fallbacks_reg <= '0;
    end else begin
      state_reg     <= state_next;
      bound_reg     <= bound_next;
      mask_reg      <= mask_next;
      remaining_reg <= remaining_next;
      tries_reg     <= tries_next;
      data_reg      <= data_next;
      last_reg      <= last_next;
      valid_reg     <= valid_next;
      rejects_reg   <= rejects_next;
      fallbacks_reg <= fallbacks_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bound_next     = bound_reg;
    mask_next      = mask_reg;
    remaining_next = remaining_reg;
    tries_next     = tries_reg;
    data_next      = data_reg;
    last_next      = last_reg;
    valid_next     = valid_reg;
    rejects_next   = rejects_reg;
    fallbacks_next = fallbacks_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid_i) begin
          bound_next     = req_bound_i;
          mask_next      = req_mask;
          remaining_next = req_count_i;
          tries_next     = '0;
          if (req_count_i != '0) begin
            state_next = ST_DRAW;
          end
        end
      end
      ST_DRAW: begin
        if (draw_hit) begin
          data_next  = draw_s;
          valid_next = 1'b1;
          last_next  = is_last;
          state_next = ST_HOLD;
        end else if (tries_reg != LAST_TRY) begin
          tries_next = tries_reg + TRY_W'(1);
          if (rejects_reg != '1) begin
            rejects_next = rejects_reg + STAT_W'(1);
          end
        end else begin
          data_next  = fallback_val;
          valid_next = 1'b1;
          last_next  = is_last;
          state_next = ST_HOLD;
          if (fallbacks_reg != '1) begin
            fallbacks_next = fallbacks_reg + STAT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (out_ready_i) begin
          valid_next     = 1'b0;
          remaining_next = remaining_reg - CNT_W'(1);
          tries_next     = '0;
          state_next     = is_last ? ST_IDLE : ST_DRAW;
        end
      end
      default: begin
        state_next = ST_IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  assign req_ready_o      = (state_reg == ST_IDLE);
  assign busy_o           = (state_reg == ST_DRAW) || (state_reg == ST_HOLD);
  assign out_valid_o      = valid_reg;
  assign out_data_o       = data_reg;
  assign out_last_o       = last_reg;
  assign stat_rejects_o   = rejects_reg;
  assign stat_fallbacks_o = fallbacks_reg;

endmodule
